sad_min_select: RTL

SAD_MIN_SELECT -- requirements
Module: sad_min_select

---
 rtl/sad_min_select.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sad_min_select.sv
// -----------------------------------------------------------------------------
// sad_min_select
//   Tracks the minimum-SAD candidate for each of four coding blocks while a
//   motion search runs, then drains the four results (CB0..CB3) over a
//   valid/ready output port.
//
//   Optional feature (compile-time macro SAD_TIE_MV_COST_EN):
//     undefined : on equal SAD the earlier candidate is kept.
//     defined   : on equal SAD the candidate with the strictly smaller
//                 |mv_x| + |mv_y| replaces the stored minimum.
//
// Ports
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   start         : one-cycle pulse, clears trackers and enters TRACK
//   sad_valid     : qualifies sad_in / sad_cb / sad_row / sad_col
//   sad_in        : candidate SAD (unsigned, SAD_W bits)
//   sad_cb        : coding-block index 0..3 of the candidate
//   sad_row       : search row count 0..63
//   sad_col       : search column count 0..31
//   search_done   : one-cycle pulse, search window finished
//   out_ready     : downstream accepts the presented result
//   out_valid     : result presented
//   out_cb        : coding-block index of the presented result
//   out_sad       : minimum SAD (all ones when no candidate was seen)
//   out_mv_x      : two's complement sad_col - COL_CTR at the minimum
//   out_mv_y      : two's complement sad_row - ROW_CTR at the minimum
//   out_hit       : at least one candidate was seen for out_cb
//   busy          : registered, high in TRACK and DRAIN
//   dbg_state     : current FSM state (0 IDLE, 1 TRACK, 2 DRAIN)
//
// Handshake: a result transfers on a rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low all
// out_* signals hold their value. After a transfer the next CB is presented
// on the following cycle, and out_valid drops the cycle after the CB3
// transfer.
// -----------------------------------------------------------------------------
module sad_min_select #(
  parameter int SAD_W   = 16,
  parameter int ROW_CTR = 32,
  parameter int COL_CTR = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad_in,
  input  logic [1:0]       sad_cb,
  input  logic [6:0]       sad_row,
  input  logic [4:0]       sad_col,
  input  logic             search_done,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [1:0]       out_cb,
  output logic [SAD_W-1:0] out_sad,
  output logic [5:0]       out_mv_x,
  output logic [6:0]       out_mv_y,
  output logic             out_hit,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state;

  // Per-CB trackers
  logic [SAD_W-1:0] best_sad [4];
  logic [6:0]       best_row [4];
  logic [4:0]       best_col [4];
  logic [3:0]       hit;

  assign dbg_state = state;

  // Zero-extend, subtract the centre, keep the low bits (two's complement).
  function automatic logic [5:0] mv_x_of(input logic [4:0] col);
    logic [31:0] d;
    d = {27'd0, col} - 32'(COL_CTR);
    return d[5:0];
  endfunction

  function automatic logic [6:0] mv_y_of(input logic [6:0] row);
    logic [31:0] d;
    d = {25'd0, row} - 32'(ROW_CTR);
    return d[6:0];
  endfunction

`ifdef SAD_TIE_MV_COST_EN
  // |mv_x| + |mv_y|; the largest magnitudes (16 and 32) still fit unsigned.
  function automatic logic [6:0] mv_cost(input logic [6:0] row, input logic [4:0] col);
    logic [5:0] mx;
    logic [6:0] my;
    logic [6:0] ax;
    logic [6:0] ay;
    mx = mv_x_of(col);
    my = mv_y_of(row);
    ax = {1'b0, (mx[5] ? (~mx + 6'd1) : mx)};
    ay = my[6] ? (~my + 7'd1) : my;
    return ax + ay;
  endfunction
`endif

  // Candidate replaces the stored minimum of its CB.
  logic cand_better;

  always_comb begin
    cand_better = !hit[sad_cb] || (sad_in < best_sad[sad_cb]);
`ifdef SAD_TIE_MV_COST_EN
    if (hit[sad_cb] && (sad_in == best_sad[sad_cb]) &&
        (mv_cost(sad_row, sad_col) < mv_cost(best_row[sad_cb], best_col[sad_cb])))
      cand_better = 1'b1;
`endif
  end

  // Source of the next result to present. On DRAIN entry tracker 0 is read
  // through a bypass so a candidate arriving with search_done is included.
  logic [1:0]       nxt_cb;
  logic [SAD_W-1:0] sel_sad;
  logic [6:0]       sel_row;
  logic [4:0]       sel_col;
  logic             sel_hit;
  logic [SAD_W-1:0] ld_sad;
  logic [5:0]       ld_mv_x;
  logic [6:0]       ld_mv_y;

  always_comb begin
    nxt_cb  = 2'(out_cb + 2'd1);
    sel_sad = best_sad[nxt_cb];
    sel_row = best_row[nxt_cb];
    sel_col = best_col[nxt_cb];
    sel_hit = hit[nxt_cb];
    if (state == ST_TRACK) begin
      if (sad_valid && (sad_cb == 2'd0) && cand_better) begin
        sel_sad = sad_in;
        sel_row = sad_row;
        sel_col = sad_col;
        sel_hit = 1'b1;
      end else begin
        sel_sad = best_sad[0];
        sel_row = best_row[0];
        sel_col = best_col[0];
        sel_hit = hit[0] | (sad_valid && (sad_cb == 2'd0));
      end
    end
    // A CB that never saw a candidate reports all-ones SAD and zero MV.
    ld_sad  = sel_hit ? sel_sad : '1;
    ld_mv_x = sel_hit ? mv_x_of(sel_col) : 6'd0;
    ld_mv_y = sel_hit ? mv_y_of(sel_row) : 7'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_cb    <= 2'd0;
      out_sad   <= '0;
      out_mv_x  <= 6'd0;
      out_mv_y  <= 7'd0;
      out_hit   <= 1'b0;
      hit       <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        best_sad[i] <= '1;
        best_row[i] <= 7'd0;
        best_col[i] <= 5'd0;
      end
    end else if (start) begin
      // start wins over search_done and any handshake in the same cycle
      state     <= ST_TRACK;
      busy      <= 1'b1;
      out_valid <= 1'b0;
      hit       <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        best_sad[i] <= '1;
        best_row[i] <= 7'd0;
        best_col[i] <= 5'd0;
      end
    end else begin
      case (state)
        ST_TRACK: begin
          if (sad_valid) begin
            if (cand_better) begin
              best_sad[sad_cb] <= sad_in;
              best_row[sad_cb] <= sad_row;
              best_col[sad_cb] <= sad_col;
            end
            hit[sad_cb] <= 1'b1;
          end
          if (search_done) begin
            state     <= ST_DRAIN;
            out_valid <= 1'b1;
            out_cb    <= 2'd0;
            out_sad   <= ld_sad;
            out_mv_x  <= ld_mv_x;
            out_mv_y  <= ld_mv_y;
            out_hit   <= sel_hit;
          end
        end
        ST_DRAIN: begin
          if (out_valid && out_ready) begin
            if (out_cb == 2'd3) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
            end else begin
              out_cb   <= nxt_cb;
              out_sad  <= ld_sad;
              out_mv_x <= ld_mv_x;
              out_mv_y <= ld_mv_y;
              out_hit  <= sel_hit;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
